// File: rtl/sub_scan_ctrl_pkg.sv
// rtl/sub_scan_ctrl_pkg.sv - shared constants and types for the subtractor display
package sub_disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam int         SLOT_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        WAIT
    } state_t;

endpackage

// File: rtl/sub_scan_ctrl_if.sv
// rtl/sub_scan_ctrl_if.sv - operand/load and digit-pin bundle for sub_scan_ctrl
interface sub_scan_ctrl_if;

    logic [2:0] a;
    logic [2:0] b;
    logic       load;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] an;

    modport master (output a, output b, output load, input busy, input seg, input an);
    modport slave  (input a, input b, input load, output busy, output seg, output an);

endinterface

// File: rtl/sub_scan_ctrl_seg7_hex_dec.sv
// rtl/sub_scan_ctrl_seg7_hex_dec.sv - hex nibble to active-low 7-segment pattern, dp off
module seg7_hex_dec (
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/sub_scan_ctrl.sv
// rtl/sub_scan_ctrl.sv - captures a/b, computes a-b, scans a, b, sign and magnitude on four digits
module sub_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    sub_scan_ctrl_if.slave io
);

    import sub_disp_pkg::*;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0]  div;
    logic [SLOT_W-1:0] slot;
    logic              tc;

    state_t state, state_nx;
    logic   accept, capt, commit;

    logic [2:0] a_r, b_r;
    logic [3:0] diff;
    logic       pend_neg;
    logic [2:0] pend_mag;

    logic       sh_valid, sh_neg;
    logic [2:0] sh_a, sh_b, sh_mag;

    logic [3:0] dig;
    logic [7:0] dig_seg, seg_nx, seg_q;
    logic [3:0] an_nx, an_q;

    assign tc   = (div == DIV_W'(SCAN_DIV - 1));
    assign diff = {1'b0, a_r} - {1'b0, b_r};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A commit point seen while still in CAPT is simply missed; WAIT catches the next frame.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capt     = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: if (io.load) begin
                accept   = 1'b1;
                state_nx = CAPT;
            end
            CAPT: begin
                capt     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (tc && slot == SLOT_W'(3)) begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            slot     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            pend_neg <= 1'b0;
            pend_mag <= '0;
            sh_valid <= 1'b0;
            sh_neg   <= 1'b0;
            sh_a     <= '0;
            sh_b     <= '0;
            sh_mag   <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= 4'b1111;
        end else begin
            div   <= tc ? '0 : div + 1'b1;
            slot  <= tc ? slot + 1'b1 : slot;
            seg_q <= seg_nx;
            an_q  <= an_nx;
            if (accept) begin
                a_r <= io.a;
                b_r <= io.b;
            end
            if (capt) begin
                pend_neg <= diff[3];
                pend_mag <= diff[3] ? (~diff[2:0] + 3'd1) : diff[2:0];
            end
            // a_r/b_r are frozen until the next accept, so they double as pending operands.
            if (commit) begin
                sh_valid <= 1'b1;
                sh_neg   <= pend_neg;
                sh_mag   <= pend_mag;
                sh_a     <= a_r;
                sh_b     <= b_r;
            end
        end
    end

    always_comb begin
        dig = 4'h0;
        case (slot)
            2'd0: dig = {1'b0, sh_mag};
            2'd2: dig = {1'b0, sh_b};
            2'd3: dig = {1'b0, sh_a};
            default: dig = 4'h0;
        endcase
    end

    seg7_hex_dec u_dec (
        .hex (dig),
        .seg (dig_seg)
    );

    always_comb begin
        seg_nx = dig_seg;
        if (!sh_valid)
            seg_nx = SEG_BLANK;
        else if (slot == SLOT_W'(1))
            seg_nx = sh_neg ? SEG_MINUS : SEG_BLANK;
        an_nx = (div < DIV_W'(BLANK_CYC)) ? 4'b1111 : ~(4'b0001 << slot);
    end

    assign io.seg  = seg_q;
    assign io.an   = an_q;
    assign io.busy = (state != IDLE);

endmodule

// File: tb/tb_sub_scan_ctrl.sv
// tb/tb_sub_scan_ctrl.sv - directed self-checking bench for sub_scan_ctrl
module tb_sub_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sub_scan_ctrl_if io ();

    sub_scan_ctrl #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_an(input string tag, input logic [3:0] exp);
        for (int i = 0; i < 100 && io.an !== exp; i++) tick();
        chk(tag, {4'h0, io.an}, {4'h0, exp});
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && io.busy !== 1'b0; i++) tick();
        chk(tag, {7'h0, io.busy}, 8'h00);
    endtask

    task automatic do_load(input string tag, input logic [2:0] a, input logic [2:0] b);
        io.a    = a;
        io.b    = b;
        io.load = 1'b1;
        tick();
        io.load = 1'b0;
        chk(tag, {7'h0, io.busy}, 8'h01);
    endtask

    // Catch the first unblanked cycle of slot0, then step one slot (8 cycles) at a time.
    task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] exp_seg [4];
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        wait_an({tag, "_an0"}, 4'b1110);
        chk({tag, "_s0"}, io.seg, exp_seg[0]);
        for (int k = 1; k < 4; k++) begin
            repeat (8) tick();
            chk($sformatf("%s_an%0d", tag, k), {4'h0, io.an}, {4'h0, ~(4'b0001 << k)});
            chk($sformatf("%s_s%0d", tag, k), io.seg, exp_seg[k]);
        end
    endtask

    initial begin
        int nonblank;
        io.a    = 3'd0;
        io.b    = 3'd0;
        io.load = 1'b0;

        repeat (3) tick();
        chk("rst_seg", io.seg, 8'hFF);
        chk("rst_an", {4'h0, io.an}, 8'h0F);
        chk("rst_busy", {7'h0, io.busy}, 8'h00);
        rst = 1'b0;

        for (int n = 1; n <= 8; n++) begin
            tick();
            chk($sformatf("slot0_an_c%0d", n), {4'h0, io.an}, (n <= 2) ? 8'h0F : 8'h0E);
        end
        chk("blank_shadow_seg", io.seg, 8'hFF);

        do_load("ld52_busy", 3'd5, 3'd2);
        wait_idle("ld52_idle");
        check_frame("f52", 8'hB0, 8'hFF, 8'hA4, 8'h92);

        do_load("ld25_busy", 3'd2, 3'd5);
        wait_idle("ld25_idle");
        check_frame("f25", 8'hB0, 8'hBF, 8'h92, 8'hA4);

        do_load("ld70_busy", 3'd7, 3'd0);
        wait_idle("ld70_idle");
        check_frame("f70", 8'hF8, 8'hFF, 8'hC0, 8'hF8);

        do_load("ld00_busy", 3'd0, 3'd0);
        wait_idle("ld00_idle");
        check_frame("f00", 8'hC0, 8'hFF, 8'hC0, 8'hC0);

        do_load("ld16_busy", 3'd1, 3'd6);
        do_load("ld33_ignored_busy", 3'd3, 3'd3);
        wait_idle("ld16_idle");
        check_frame("f16", 8'h92, 8'hBF, 8'h82, 8'hF9);

        wait_an("slot2_seen", 4'b1011);
        do_load("ld41_busy", 3'd4, 3'd1);
        wait_an("slot3_old_an", 4'b0111);
        chk("slot3_old_seg", io.seg, 8'hF9);
        chk("slot3_old_busy", {7'h0, io.busy}, 8'h01);
        wait_an("wrap_an", 4'b1110);
        chk("wrap_new_seg", io.seg, 8'hB0);
        chk("wrap_busy", {7'h0, io.busy}, 8'h00);
        check_frame("f41", 8'hB0, 8'hFF, 8'hF9, 8'h99);

        do_load("ld61_busy", 3'd6, 3'd1);
        repeat (3) tick();
        chk("wait_busy", {7'h0, io.busy}, 8'h01);
        rst = 1'b1;
        tick();
        chk("mid_rst_seg", io.seg, 8'hFF);
        chk("mid_rst_an", {4'h0, io.an}, 8'h0F);
        chk("mid_rst_busy", {7'h0, io.busy}, 8'h00);
        rst = 1'b0;
        nonblank = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (io.seg !== 8'hFF) nonblank++;
        end
        chk("post_rst_no_stale", nonblank[7:0], 8'h00);
        chk("post_rst_busy", {7'h0, io.busy}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_scan_ctrl.md
# sub_scan_ctrl

Scan controller for the switch-operand subtractor display. It captures 3-bit operands `a` and `b` on a load request and computes the signed difference `a-b`. It then time-multiplexes one shared 7-segment decoder across four common-anode digits: `a`, `b`, the sign, and the magnitude. It sits between the board switches/button logic and the digit/segment pins, and replaces the single static-digit drive.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all anodes off (anti-ghosting).
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `a` input 3: minuend, unsigned 0..7.
- `b` input 3: subtrahend, unsigned 0..7.
- `load` input 1: single-cycle request to capture `a`/`b`.
- `busy` output 1: high while a captured result waits for frame commit; `load` is ignored while high.
- `seg` output 8: active-low segments, bit7 = dp (always 1 = off), bits6..0 = g..a.
- `an` output 4: active-low digit enables; `an[0]` = rightmost digit.

## Operation
- Operand path:
  - On a cycle with `load`=1 and `busy`=0, register `a` and `b` and set `busy`.
  - Next cycle, form a 4-bit two's-complement `diff = {1'b0,a} - {1'b0,b}`, giving a range of −7..+7.
  - Store `neg = diff[3]` and `mag = neg ? -diff : diff` (3 bits) in pending registers.
- Shadow/commit:
  - Four shadow digit codes drive the display: slot0 = `mag`, slot1 = sign, slot2 = `b`, slot3 = `a`.
  - The sign code is minus (8'b10111111) if `neg`, else blank (8'hFF).
  - Pending values copy into the shadow only at frame commit: the cycle where the divider is at terminal count and the slot index is 3. That same edge clears `busy`.
  - A display never shows a mix of old and new operands.
- Scanner:
  - A divider runs 0..`SCAN_DIV`−1 continuously.
  - At terminal count, the 2-bit slot index advances 0→1→2→3→0.
  - While divider < `BLANK_CYC`, `an`=4'b1111. Otherwise `an` has a single 0 at the bit equal to the slot index.
  - `seg` is the shadow code of the current slot, decoded through `seg7_hex_dec`. Digit codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8. Hex 8..F is also supported by the decoder.
- State machine:
  - IDLE (`busy`=0) → CAPT on accepted `load`.
  - CAPT → WAIT after 1 cycle (pending written).
  - WAIT → IDLE on frame commit.
  - If the commit point arrives while in CAPT, commit is deferred to the next frame.
- Simultaneous events: `load` on the commit cycle with `busy`=1 is ignored. With `busy`=0, it is accepted normally and commits at the following frame.

## Timing
- Reset values, applied at the next edge after `rst`=1:
  - `seg`=8'hFF, `an`=4'b1111, `busy`=0.
  - Divider=0, slot index=0, state IDLE.
  - Shadow all 8'hFF (blank), pending cleared.
- `rst` mid-frame or mid-WAIT: the pending result is discarded, with no partial commit.
- Pipeline for a load accepted at edge T:
  - `busy`=1 after T.
  - Pending valid after T+1.
  - Commit at the first subsequent slot-3 terminal-count edge at or after T+2.
  - Worst case ≈ 4·`SCAN_DIV`+2 cycles.
- `seg`/`an` are registered: they reflect the divider/slot state one cycle later. That registered cycle counts inside the blanking window.
- The divider and slot index are never paused by `load`, `busy` or commit.

## Structure
- Package `sub_disp_pkg`:
  - Constants `SEG_BLANK`=8'hFF, `SEG_MINUS`=8'hBF.
  - State enum IDLE/CAPT/WAIT.
  - Slot index width (2).
- Sub-module `seg7_hex_dec`: combinational 4-bit in → 8-bit active-low segments (dp=1). Reused by other display blocks.

## Test plan
Run with `SCAN_DIV`=8, `BLANK_CYC`=2.
- Reset 3 cycles → `seg`=FF, `an`=1111, `busy`=0. After release, `an` shows 1110 in cycles 3..8 of slot0 and 1111 in cycles 1..2 of each slot.
- `a`=5, `b`=2, load pulse → `busy`=1 until commit. The next frame shows slot0=B0 (3), slot1=FF, slot2=A4, slot3=92.
- `a`=2, `b`=5 → slot0=B0 (3), slot1=BF (minus), slot2=92, slot3=A4.
- `a`=7, `b`=0, then `a`=0, `b`=0 → first slot0=F8, slot1=FF. Then slot0=C0, slot1=FF. Never shows "−0".
- `load` with new operands while `busy`=1 → ignored: the display shows the first operands and `busy` falls at commit. A load accepted during slot2 → no shadow change until the slot index wraps to 0.
- `rst` pulse during WAIT → next cycle outputs at reset values. The old pending value never appears.
